// File: rtl/vga_pkg.sv
// Shared VGA timing constants, pixel colour type, bounce direction type and
// the eight-colour palette used by the bouncing-box pattern stage.
package vga_pkg;

  localparam int HBP  = 144;
  localparam int VBP  = 31;
  localparam int HPIX = 640;
  localparam int VPIX = 480;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_e;

  // red, green, blue, yellow, cyan, magenta, white, orange
  localparam rgb12_t PALETTE [0:7] = '{
    rgb12_t'(12'hF00), rgb12_t'(12'h0F0), rgb12_t'(12'h00F), rgb12_t'(12'hFF0),
    rgb12_t'(12'h0FF), rgb12_t'(12'hF0F), rgb12_t'(12'hFFF), rgb12_t'(12'hF80)
  };

endpackage

// File: rtl/bounce_axis.sv
// One axis of the bouncing box: position in [0, LIMIT], stepping STEP per
// enabled tick and reversing direction when it reaches either end.
module bounce_axis
  import vga_pkg::*;
#(
  parameter int LIMIT = 608,
  parameter int STEP  = 4
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        tick_en,
  output logic [10:0] pos,
  output dir_e        dir,
  output logic        flip
);

  localparam logic [10:0] LIM_W  = 11'(LIMIT);
  localparam logic [10:0] STEP_W = 11'(STEP);

  logic [10:0] pos_q, pos_d;
  dir_e        dir_q, dir_d;
  logic        flip_s;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pos_q <= 11'd0;
      dir_q <= DIR_POS;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  // Comparisons are arranged so the subtraction only happens when pos > STEP.
  always_comb begin
    pos_d  = pos_q;
    dir_d  = dir_q;
    flip_s = 1'b0;
    if (tick_en) begin
      case (dir_q)
        DIR_POS: begin
          if (pos_q + STEP_W >= LIM_W) begin
            pos_d  = LIM_W;
            dir_d  = DIR_NEG;
            flip_s = 1'b1;
          end else begin
            pos_d = pos_q + STEP_W;
          end
        end
        DIR_NEG: begin
          if (pos_q <= STEP_W) begin
            pos_d  = 11'd0;
            dir_d  = DIR_POS;
            flip_s = 1'b1;
          end else begin
            pos_d = pos_q - STEP_W;
          end
        end
        default: begin
          pos_d = pos_q;
          dir_d = DIR_POS;
        end
      endcase
    end else begin
      pos_d = pos_q;
    end
  end

  assign pos  = pos_q;
  assign dir  = dir_q;
  assign flip = flip_s;

endmodule

// File: rtl/vga_bounce_box.sv
// Bouncing-box pattern stage: a solid square moving once per frame, changing
// colour on each bounce. Optional white screen border via VGA_BOUNCE_BORDER_EN.
module vga_bounce_box
  import vga_pkg::*;
#(
  parameter int          BOX    = 32,
  parameter int          STEP   = 4,
  parameter logic [11:0] BG_RGB = 12'h000
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        vidon,
  input  logic [10:0] hc,
  input  logic [10:0] vc,
  input  logic        vsync,
  input  logic        pause,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        bounce
);

  localparam logic [10:0] BOX_W = 11'(BOX);

  logic        vs_q;
  logic        tick_s;
  logic [10:0] bx_s, by_s;
  dir_e        dx_s, dy_s;
  logic        flip_x_s, flip_y_s;
  logic [2:0]  col_q, col_d;
  logic        bounce_q, bounce_d;
  rgb12_t      rgb_q, rgb_d;
  logic [10:0] px_s, py_s;
  logic        in_box_s;

  // A paused tick is dropped entirely, so nothing moves and no bounce fires.
  assign tick_s = vs_q & ~vsync & ~pause;

  bounce_axis #(.LIMIT(HPIX - BOX), .STEP(STEP)) u_axis_x (
    .clk    (clk),
    .clr_n  (clr_n),
    .tick_en(tick_s),
    .pos    (bx_s),
    .dir    (dx_s),
    .flip   (flip_x_s)
  );

  bounce_axis #(.LIMIT(VPIX - BOX), .STEP(STEP)) u_axis_y (
    .clk    (clk),
    .clr_n  (clr_n),
    .tick_en(tick_s),
    .pos    (by_s),
    .dir    (dy_s),
    .flip   (flip_y_s)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      vs_q     <= 1'b1;
      col_q    <= 3'd0;
      bounce_q <= 1'b0;
      rgb_q    <= rgb12_t'(12'h000);
    end else begin
      vs_q     <= vsync;
      col_q    <= col_d;
      bounce_q <= bounce_d;
      rgb_q    <= rgb_d;
    end
  end

  // A corner hit flips both axes but still counts as a single bounce.
  always_comb begin
    bounce_d = flip_x_s | flip_y_s;
    if (bounce_d) begin
      col_d = col_q + 3'd1;
    end else begin
      col_d = col_q;
    end
  end

  assign px_s     = hc - 11'(HBP);
  assign py_s     = vc - 11'(VBP);
  assign in_box_s = vidon & (px_s >= bx_s) & (px_s < bx_s + BOX_W)
                  & (py_s >= by_s) & (py_s < by_s + BOX_W);

  always_comb begin
    rgb_d = rgb12_t'(12'h000);
    if (vidon) begin
`ifdef VGA_BOUNCE_BORDER_EN
      if ((px_s == 11'd0) || (px_s == 11'(HPIX - 1)) ||
          (py_s == 11'd0) || (py_s == 11'(VPIX - 1))) begin
        rgb_d = rgb12_t'(12'hFFF);
      end else if (in_box_s) begin
        rgb_d = PALETTE[col_q];
      end else begin
        rgb_d = rgb12_t'(BG_RGB);
      end
`else
      if (in_box_s) begin
        rgb_d = PALETTE[col_q];
      end else begin
        rgb_d = rgb12_t'(BG_RGB);
      end
`endif
    end else begin
      rgb_d = rgb12_t'(12'h000);
    end
  end

  assign red    = rgb_q.r;
  assign green  = rgb_q.g;
  assign blue   = rgb_q.b;
  assign bounce = bounce_q;

endmodule

// File: tb/tb_vga_bounce_box.sv
// Directed self-checking bench for vga_bounce_box (default build, no border).
module tb_vga_bounce_box;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        vidon;
  logic [10:0] hc, vc;
  logic        vsync;
  logic        pause;
  logic [3:0]  red, green, blue;
  logic        bounce;

  int checks = 0;
  int errors = 0;

  vga_bounce_box dut (
    .clk   (clk),
    .clr_n (clr_n),
    .vidon (vidon),
    .hc    (hc),
    .vc    (vc),
    .vsync (vsync),
    .pause (pause),
    .red   (red),
    .green (green),
    .blue  (blue),
    .bounce(bounce)
  );

  always #20 clk = ~clk;

  // Present one pixel coordinate (relative to the visible origin) and return
  // the registered colour one clock later.
  task automatic probe(input int px, input int py, input logic vid, output logic [11:0] rgb);
    hc    = 11'(144 + px);
    vc    = 11'(31 + py);
    vidon = vid;
    @(posedge clk);
    @(negedge clk);
    rgb = {red, green, blue};
  endtask

  // One vsync falling edge; b1 is bounce in the tick cycle, b2 the cycle after.
  task automatic do_tick(output logic b1, output logic b2);
    vsync = 1'b0;
    @(posedge clk);
    @(negedge clk);
    b1    = bounce;
    vsync = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b2    = bounce;
  endtask

  task automatic run_ticks(input int n, output int nb, output int nlong);
    logic b1, b2;
    nb = 0;
    nlong = 0;
    for (int i = 0; i < n; i++) begin
      do_tick(b1, b2);
      if (b1) nb++;
      if (b2) nlong++;
    end
  endtask

  task automatic test_reset;
    logic [11:0] rgb;
    clr_n = 1'b0; vidon = 1'b1; hc = 11'd144; vc = 11'd31; vsync = 1'b1; pause = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({red, green, blue} !== 12'h000) begin
      errors++; $display("FAIL reset_rgb got %h want %h", {red, green, blue}, 12'h000);
    end
    checks++;
    if (bounce !== 1'b0) begin
      errors++; $display("FAIL reset_bounce got %b want 0", bounce);
    end
    clr_n = 1'b1;
    probe(0, 0, 1'b1, rgb);
    checks++;
    if (rgb !== 12'hF00) begin
      errors++; $display("FAIL reset_first_pixel got %h want %h", rgb, 12'hF00);
    end
  endtask

  task automatic test_one_frame;
    logic b1, b2;
    logic [11:0] rgb;
    do_tick(b1, b2);
    checks++;
    if (b1 !== 1'b0) begin
      errors++; $display("FAIL frame_bounce got %b want 0", b1);
    end
    probe(3, 3, 1'b1, rgb);
    checks++;
    if (rgb !== 12'h000) begin
      errors++; $display("FAIL frame_px3 got %h want %h", rgb, 12'h000);
    end
    probe(4, 4, 1'b1, rgb);
    checks++;
    if (rgb !== 12'hF00) begin
      errors++; $display("FAIL frame_px4 got %h want %h", rgb, 12'hF00);
    end
    probe(35, 35, 1'b1, rgb);
    checks++;
    if (rgb !== 12'hF00) begin
      errors++; $display("FAIL frame_px35 got %h want %h", rgb, 12'hF00);
    end
    probe(36, 4, 1'b1, rgb);
    checks++;
    if (rgb !== 12'h000) begin
      errors++; $display("FAIL frame_px36 got %h want %h", rgb, 12'h000);
    end
  endtask

  // Ticks 2..153: y bounces at tick 112 (by=448), x at tick 152 (bx=608).
  task automatic test_right_edge;
    int nb, nlong;
    logic b1, b2;
    logic [11:0] rgb;
    run_ticks(110, nb, nlong);
    checks++;
    if (nb !== 0) begin
      errors++; $display("FAIL edge_no_early_bounce got %0d want 0", nb);
    end
    do_tick(b1, b2);
    checks++;
    if (b1 !== 1'b1 || b2 !== 1'b0) begin
      errors++; $display("FAIL bottom_bounce_pulse got %b%b want 10", b1, b2);
    end
    probe(448, 448, 1'b1, rgb);
    checks++;
    if (rgb !== 12'h0F0) begin
      errors++; $display("FAIL bottom_box got %h want %h", rgb, 12'h0F0);
    end
    probe(448, 447, 1'b1, rgb);
    checks++;
    if (rgb !== 12'h000) begin
      errors++; $display("FAIL bottom_above got %h want %h", rgb, 12'h000);
    end
    run_ticks(39, nb, nlong);
    checks++;
    if (nb !== 0) begin
      errors++; $display("FAIL edge_mid_bounce got %0d want 0", nb);
    end
    probe(604, 292, 1'b1, rgb);
    checks++;
    if (rgb !== 12'h0F0) begin
      errors++; $display("FAIL pre_edge_box got %h want %h", rgb, 12'h0F0);
    end
    probe(603, 292, 1'b1, rgb);
    checks++;
    if (rgb !== 12'h000) begin
      errors++; $display("FAIL pre_edge_left got %h want %h", rgb, 12'h000);
    end
    do_tick(b1, b2);
    checks++;
    if (b1 !== 1'b1 || b2 !== 1'b0) begin
      errors++; $display("FAIL right_bounce_pulse got %b%b want 10", b1, b2);
    end
    probe(608, 288, 1'b1, rgb);
    checks++;
    if (rgb !== 12'h00F) begin
      errors++; $display("FAIL right_box got %h want %h", rgb, 12'h00F);
    end
    probe(607, 288, 1'b1, rgb);
    checks++;
    if (rgb !== 12'h000) begin
      errors++; $display("FAIL right_left got %h want %h", rgb, 12'h000);
    end
    probe(639, 319, 1'b1, rgb);
    checks++;
    if (rgb !== 12'h00F) begin
      errors++; $display("FAIL right_lastpix got %h want %h", rgb, 12'h00F);
    end
    do_tick(b1, b2);
    probe(604, 284, 1'b1, rgb);
    checks++;
    if (rgb !== 12'h00F || b1 !== 1'b0) begin
      errors++; $display("FAIL after_edge got %h/%b want %h/0", rgb, b1, 12'h00F);
    end
    probe(636, 284, 1'b1, rgb);
    checks++;
    if (rgb !== 12'h000) begin
      errors++; $display("FAIL after_edge_right got %h want %h", rgb, 12'h000);
    end
  endtask

  task automatic test_pause;
    int nb, nlong;
    logic [11:0] rgb;
    pause = 1'b1;
    run_ticks(3, nb, nlong);
    pause = 1'b0;
    checks++;
    if (nb !== 0 || nlong !== 0) begin
      errors++; $display("FAIL pause_bounce got %0d want 0", nb + nlong);
    end
    probe(604, 284, 1'b1, rgb);
    checks++;
    if (rgb !== 12'h00F) begin
      errors++; $display("FAIL pause_box got %h want %h", rgb, 12'h00F);
    end
    probe(603, 284, 1'b1, rgb);
    checks++;
    if (rgb !== 12'h000) begin
      errors++; $display("FAIL pause_left got %h want %h", rgb, 12'h000);
    end
    probe(604, 284, 1'b0, rgb);
    checks++;
    if (rgb !== 12'h000) begin
      errors++; $display("FAIL blank_in_box got %h want %h", rgb, 12'h000);
    end
  endtask

  // Tick 2128 hits the corner (bx 4->0, by 444->448) after 31 prior bounces.
  task automatic test_corner;
    int nb, nlong;
    logic b1, b2;
    logic [11:0] rgb;
    run_ticks(1974, nb, nlong);
    checks++;
    if (nb !== 29 || nlong !== 0) begin
      errors++; $display("FAIL corner_approach_bounces got %0d/%0d want 29/0", nb, nlong);
    end
    probe(4, 444, 1'b1, rgb);
    checks++;
    if (rgb !== 12'hF80) begin
      errors++; $display("FAIL corner_pre_box got %h want %h", rgb, 12'hF80);
    end
    probe(3, 444, 1'b1, rgb);
    checks++;
    if (rgb !== 12'h000) begin
      errors++; $display("FAIL corner_pre_left got %h want %h", rgb, 12'h000);
    end
    probe(4, 443, 1'b1, rgb);
    checks++;
    if (rgb !== 12'h000) begin
      errors++; $display("FAIL corner_pre_above got %h want %h", rgb, 12'h000);
    end
    do_tick(b1, b2);
    checks++;
    if (b1 !== 1'b1 || b2 !== 1'b0) begin
      errors++; $display("FAIL corner_pulse got %b%b want 10", b1, b2);
    end
    probe(0, 448, 1'b1, rgb);
    checks++;
    if (rgb !== 12'hF00) begin
      errors++; $display("FAIL corner_box got %h want %h", rgb, 12'hF00);
    end
    probe(31, 479, 1'b1, rgb);
    checks++;
    if (rgb !== 12'hF00) begin
      errors++; $display("FAIL corner_lastpix got %h want %h", rgb, 12'hF00);
    end
    probe(32, 448, 1'b1, rgb);
    checks++;
    if (rgb !== 12'h000) begin
      errors++; $display("FAIL corner_right got %h want %h", rgb, 12'h000);
    end
    do_tick(b1, b2);
    probe(4, 444, 1'b1, rgb);
    checks++;
    if (rgb !== 12'hF00 || b1 !== 1'b0) begin
      errors++; $display("FAIL corner_after got %h/%b want %h/0", rgb, b1, 12'hF00);
    end
    probe(3, 444, 1'b1, rgb);
    checks++;
    if (rgb !== 12'h000) begin
      errors++; $display("FAIL corner_after_left got %h want %h", rgb, 12'h000);
    end
  endtask

  task automatic test_mid_reset;
    int nb, nlong;
    logic [11:0] rgb;
    clr_n = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    run_ticks(25, nb, nlong);
    probe(100, 110, 1'b1, rgb);
    checks++;
    if (rgb !== 12'hF00) begin
      errors++; $display("FAIL midreset_before got %h want %h", rgb, 12'hF00);
    end
    #5;
    clr_n = 1'b0;
    #1;
    checks++;
    if ({red, green, blue} !== 12'h000 || bounce !== 1'b0) begin
      errors++; $display("FAIL midreset_async got %h/%b want %h/0", {red, green, blue}, bounce, 12'h000);
    end
    @(negedge clk);
    clr_n = 1'b1;
    probe(0, 0, 1'b1, rgb);
    checks++;
    if (rgb !== 12'hF00) begin
      errors++; $display("FAIL midreset_origin got %h want %h", rgb, 12'hF00);
    end
    probe(31, 31, 1'b1, rgb);
    checks++;
    if (rgb !== 12'hF00) begin
      errors++; $display("FAIL midreset_31 got %h want %h", rgb, 12'hF00);
    end
    probe(100, 110, 1'b1, rgb);
    checks++;
    if (rgb !== 12'h000) begin
      errors++; $display("FAIL midreset_oldpos got %h want %h", rgb, 12'h000);
    end
  endtask

  task automatic test_vsync_low_release;
    logic [11:0] rgb;
    clr_n = 1'b0;
    vsync = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vsync = 1'b1;
    probe(4, 4, 1'b1, rgb);
    checks++;
    if (rgb !== 12'hF00) begin
      errors++; $display("FAIL vslow_box got %h want %h", rgb, 12'hF00);
    end
    probe(3, 3, 1'b1, rgb);
    checks++;
    if (rgb !== 12'h000) begin
      errors++; $display("FAIL vslow_origin got %h want %h", rgb, 12'h000);
    end
  endtask

  initial begin
    test_reset();
    test_one_frame();
    test_right_edge();
    test_pause();
    test_corner();
    test_mid_reset();
    test_vsync_low_release();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
